// File: rtl/rtc_arb_pkg.sv
// Shared types and constants for the RTC register-bus arbiter.
package rtc_arb_pkg;
    localparam int N_REQ       = 3;
    localparam int IDX_W       = 2;
    localparam int WD_W        = 9;
    localparam int TIMEOUT_DEF = 511;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} arb_state_e;

    // Requester index successor, wrapping at N_REQ.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N_REQ - 1)) ? '0 : i + 1'b1;
    endfunction
endpackage

// File: rtl/rtc_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_pick
    import rtc_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin : pick
        logic [IDX_W-1:0] cand;
        cand = ptr;
        idx  = '0;
        any  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
            cand = next_idx(cand);
        end
        win = any ? (N_REQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter sharing the RTC register bus among three requesters,
// one complete start/done transaction at a time, with a WAIT watchdog.
module rtc_bus_arbiter
    import rtc_arb_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_wr,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    ack,
    output logic [N_REQ-1:0]    err,
    output logic [DW-1:0]       rdata,
    output logic                busy,
    output logic                bus_start,
    output logic                bus_wr,
    output logic [AW-1:0]       bus_addr,
    output logic [DW-1:0]       bus_wdata,
    input  logic                bus_done,
    input  logic [DW-1:0]       bus_rdata
);
    arb_state_e       state, state_d;
    logic [IDX_W-1:0] ptr, ptr_d, gidx, gidx_d;
    logic [WD_W-1:0]  wd_cnt, wd_d;
    logic [N_REQ-1:0] gnt_d, ack_d, err_d;
    logic [DW-1:0]    rdata_d, wdata_d;
    logic [AW-1:0]    addr_d;
    logic             busy_d, start_d, wr_d;

    logic [N_REQ-1:0] pick_win;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        gidx_d  = gidx;
        wd_d    = wd_cnt;
        gnt_d   = gnt;
        ack_d   = '0;
        err_d   = '0;
        rdata_d = rdata;
        busy_d  = busy;
        start_d = 1'b0;
        wr_d    = bus_wr;
        addr_d  = bus_addr;
        wdata_d = bus_wdata;
        case (state)
            IDLE: if (pick_any) begin
                state_d = START;
                gnt_d   = pick_win;
                gidx_d  = pick_idx;
                busy_d  = 1'b1;
                start_d = 1'b1;
                wr_d    = req_wr[pick_idx];
                addr_d  = req_addr[pick_idx*AW +: AW];
                wdata_d = req_wdata[pick_idx*DW +: DW];
            end
            START: begin
                state_d = WAIT;
                wd_d    = '0;
            end
            WAIT: begin
                // done is checked first so a done on the final watchdog edge still acks
                if (bus_done) begin
                    state_d = DONE;
                    ack_d   = gnt;
                    if (!bus_wr) rdata_d = bus_rdata;
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = gnt;
                    rdata_d = '0;
                end else begin
                    wd_d = wd_cnt + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                ptr_d   = next_idx(gidx);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            gidx      <= '0;
            wd_cnt    <= '0;
            gnt       <= '0;
            ack       <= '0;
            err       <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            bus_start <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            gidx      <= gidx_d;
            wd_cnt    <= wd_d;
            gnt       <= gnt_d;
            ack       <= ack_d;
            err       <= err_d;
            rdata     <= rdata_d;
            busy      <= busy_d;
            bus_start <= start_d;
            bus_wr    <= wr_d;
            bus_addr  <= addr_d;
            bus_wdata <= wdata_d;
        end
    end
endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: per-cycle transaction-level model plus literal checks.
module tb_rtc_bus_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, req_wr;
    logic [23:0] req_addr, req_wdata;
    logic [2:0]  gnt, ack, err;
    logic [7:0]  rdata, bus_addr, bus_wdata, bus_rdata;
    logic        busy, bus_start, bus_wr, bus_done;

    rtc_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
        .bus_start(bus_start), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_done(bus_done), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // RTC driver stand-in: done arrives drv_delay cycles after bus_start; 0 = hung.
    int         drv_delay = 1;
    int         drv_k = 0;
    logic [7:0] drv_rdata = 8'h00;
    bit         spur_req = 1'b0;

    initial begin
        bus_done  = 1'b0;
        bus_rdata = 8'h00;
        forever begin
            @(negedge clk);
            bus_done = 1'b0;
            if (reset) drv_k = 0;
            else if (bus_start) drv_k = drv_delay;
            else if (drv_k > 0) begin
                drv_k--;
                if (drv_k == 0) begin
                    bus_done  = 1'b1;
                    bus_rdata = drv_rdata;
                end
            end
            if (spur_req) begin
                bus_done  = 1'b1;
                bus_rdata = 8'hEE;
                spur_req  = 1'b0;
            end
        end
    end

    // Model: one transaction at a time, timed as edge offsets from its grant edge.
    bit         m_act, m_fin;
    int         m_t, m_g, m_ptr, m_c;
    logic [2:0] s_req, s_wr;
    logic [23:0] s_addr, s_wdata;
    logic       s_rst, s_done;
    logic [7:0] s_rdata;
    logic [2:0] e_gnt, e_ack, e_err;
    logic [7:0] e_rdata, e_addr, e_wdata;
    logic       e_wr, e_start, e_busy;

    initial begin
        m_act = 0; m_fin = 0; m_t = 0; m_g = 0; m_ptr = 0;
        e_gnt = 0; e_ack = 0; e_err = 0; e_rdata = 0; e_addr = 0; e_wdata = 0;
        e_wr = 0; e_start = 0; e_busy = 0;
        forever begin
            @(posedge clk);
            s_rst = reset; s_req = req; s_wr = req_wr; s_addr = req_addr;
            s_wdata = req_wdata; s_done = bus_done; s_rdata = bus_rdata;
            e_ack = 0; e_err = 0; e_start = 0;
            if (s_rst) begin
                m_act = 0; m_fin = 0; m_ptr = 0;
                e_gnt = 0; e_rdata = 0; e_addr = 0; e_wdata = 0; e_wr = 0;
            end else if (!m_act) begin
                for (int k = 0; k < 3; k++) begin
                    m_c = (m_ptr + k) % 3;
                    if (!m_act && s_req[m_c]) begin
                        m_act = 1; m_g = m_c;
                    end
                end
                if (m_act) begin
                    m_t = 0; m_fin = 0; e_start = 1;
                    e_gnt   = 3'b001 << m_g;
                    e_wr    = s_wr[m_g];
                    e_addr  = s_addr[m_g*8 +: 8];
                    e_wdata = s_wdata[m_g*8 +: 8];
                end
            end else if (m_fin) begin
                m_act = 0; m_ptr = (m_g + 1) % 3; e_gnt = 0;
            end else begin
                m_t++;
                if (m_t >= 2 && s_done) begin
                    e_ack = e_gnt; m_fin = 1;
                    if (!e_wr) e_rdata = s_rdata;
                end else if (m_t == TO + 1) begin
                    e_err = e_gnt; e_rdata = 0; m_fin = 1;
                end
            end
            e_busy = (e_gnt != 0);
            #1;
            n_vec++;
            if ({gnt, ack, err, rdata, busy, bus_start, bus_wr, bus_addr, bus_wdata} !==
                {e_gnt, e_ack, e_err, e_rdata, e_busy, e_start, e_wr, e_addr, e_wdata}) begin
                n_err++;
                $display("FAIL model t=%0t: got gnt=%b ack=%b err=%b rdata=%h busy=%b start=%b wr=%b addr=%h wdata=%h; want gnt=%b ack=%b err=%b rdata=%h busy=%b start=%b wr=%b addr=%h wdata=%h",
                         $time, gnt, ack, err, rdata, busy, bus_start, bus_wr, bus_addr, bus_wdata,
                         e_gnt, e_ack, e_err, e_rdata, e_busy, e_start, e_wr, e_addr, e_wdata);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // fin=0: wait for a grant; fin=1: wait for ack/err. Returns negedges waited.
    task automatic wait_for(input bit fin, input string name, output int cyc);
        cyc = 0;
        while (((fin ? (ack | err) : gnt) == 3'b000) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 50) begin
            n_vec++; n_err++;
            $display("FAIL %s: timeout waiting, got none want event", name);
        end
    endtask

    int  c;
    time t_prev;
    int  order [4] = '{0, 1, 2, 0};

    initial begin
        reset = 1'b1; req = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
        repeat (2) @(negedge clk);
        chk("reset outputs", 32'({gnt, ack, err, busy, bus_start, bus_wr, rdata}), 32'h0);
        chk("reset bus", 32'({bus_addr, bus_wdata}), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single read by poller
        drv_delay = 2; drv_rdata = 8'h45;
        req_addr[16 +: 8] = 8'h21; req_wr = 3'b000; req = 3'b100;
        wait_for(0, "read gnt", c);
        req = 3'b000;
        chk("read gnt", 32'(gnt), 32'h4);
        chk("read addr", 32'(bus_addr), 32'h21);
        chk("read wr", 32'(bus_wr), 32'h0);
        wait_for(1, "read ack", c);
        chk("read latency", 32'(c), 32'd3);
        chk("read ack", 32'(ack), 32'h4);
        chk("read rdata", 32'(rdata), 32'h45);
        @(negedge clk);
        chk("read ack pulse", 32'(ack), 32'h0);
        repeat (2) @(negedge clk);

        // All three held: order 0,1,2,0 with 4-cycle spacing
        drv_delay = 1; drv_rdata = 8'h3C;
        req_addr = 24'h302010; req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_for(0, "rr gnt", c);
            chk("rr order", 32'(gnt), 32'(3'b001 << order[i]));
            if (i > 0) chk("rr spacing", 32'(($time - t_prev) / 10), 32'd4);
            t_prev = $time;
            wait_for(1, "rr ack", c);
            chk("rr ack", 32'(ack), 32'(3'b001 << order[i]));
            if (i == 3) req = 3'b000;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // Stopwatch write; ptr is now 1
        drv_rdata = 8'hAA;
        req_wr = 3'b001; req_addr[0 +: 8] = 8'h00; req_wdata[0 +: 8] = 8'h05; req = 3'b001;
        wait_for(0, "wr gnt", c);
        req = 3'b000;
        chk("wr bus_wr", 32'(bus_wr), 32'h1);
        chk("wr wdata", 32'(bus_wdata), 32'h05);
        chk("wr addr", 32'(bus_addr), 32'h00);
        wait_for(1, "wr ack", c);
        chk("wr ack", 32'(ack), 32'h1);
        chk("wr rdata kept", 32'(rdata), 32'h3C);
        @(negedge clk);
        req_wr = 3'b000;
        repeat (2) @(negedge clk);

        // Hung driver: err 9 cycles after bus_start, then next request served
        drv_delay = 0; req = 3'b010;
        wait_for(0, "hang gnt", c);
        req = 3'b000;
        wait_for(1, "hang err", c);
        chk("hang latency", 32'(c), 32'd9);
        chk("hang err", 32'(err), 32'h2);
        chk("hang no ack", 32'(ack), 32'h0);
        chk("hang rdata", 32'(rdata), 32'h00);
        @(negedge clk);
        drv_delay = 1; drv_rdata = 8'h77; req = 3'b001;
        wait_for(0, "post-hang gnt", c);
        req = 3'b000;
        wait_for(1, "post-hang ack", c);
        chk("post-hang ack", 32'(ack), 32'h1);
        chk("post-hang rdata", 32'(rdata), 32'h77);
        repeat (3) @(negedge clk);

        // Done on the last watchdog edge acks; one edge later is too late
        drv_delay = 8; drv_rdata = 8'h5A; req = 3'b100;
        wait_for(0, "edge gnt", c);
        req = 3'b000;
        wait_for(1, "edge fin", c);
        chk("edge latency", 32'(c), 32'd9);
        chk("edge ack", 32'(ack), 32'h4);
        chk("edge no err", 32'(err), 32'h0);
        chk("edge rdata", 32'(rdata), 32'h5A);
        repeat (2) @(negedge clk);
        drv_delay = 9; drv_rdata = 8'h66; req = 3'b001;
        wait_for(0, "late gnt", c);
        req = 3'b000;
        wait_for(1, "late fin", c);
        chk("late err", 32'(err), 32'h1);
        chk("late rdata", 32'(rdata), 32'h00);
        repeat (4) @(negedge clk);

        // Spurious done while idle
        spur_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("spurious outs", 32'({gnt, ack, err, busy, bus_start}), 32'h0);
        chk("spurious rdata", 32'(rdata), 32'h00);

        // Set ptr to 2, then reset during WAIT; ptr must return to 0
        drv_delay = 1; drv_rdata = 8'h12; req = 3'b010;
        wait_for(0, "pre-rst gnt", c);
        req = 3'b000;
        wait_for(1, "pre-rst ack", c);
        repeat (2) @(negedge clk);
        drv_delay = 0; req = 3'b100;
        wait_for(0, "rst gnt", c);
        req = 3'b000;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async reset", 32'({gnt, busy, ack, err, bus_start}), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drv_delay = 1; req = 3'b110;
        wait_for(0, "post-rst gnt", c);
        req = 3'b000;
        chk("post-rst gnt", 32'(gnt), 32'h2);
        wait_for(1, "post-rst ack", c);
        chk("post-rst ack", 32'(ack), 32'h2);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
